// File: rtl/sb_arb_pkg.sv
// ============================================================================
// Module      : sb_arb_pkg
// Description : Shared types, size codes and alignment helper for sb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        RESPOND  = 2'd3
    } sb_state_e;

    localparam logic [2:0] SB_SIZE_B = 3'd0;
    localparam logic [2:0] SB_SIZE_H = 3'd1;
    localparam logic [2:0] SB_SIZE_W = 3'd2;
    localparam logic [2:0] SB_SIZE_D = 3'd3;

    // Sizes above a doubleword are unsupported and reported as misaligned.
    function automatic logic sb_misaligned(input logic [2:0] addr_lo, input logic [2:0] size);
        case (size)
            SB_SIZE_B: return 1'b0;
            SB_SIZE_H: return addr_lo[0];
            SB_SIZE_W: return |addr_lo[1:0];
            SB_SIZE_D: return |addr_lo;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sb_rr_arbiter.sv
// ============================================================================
// Module      : sb_rr_arbiter
// Description : NUM_REQ-way requester pick with round-robin pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_rr_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ROUND_ROBIN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic               valid_o,
    output logic [1:0]         idx_o
);

    localparam logic [2:0] NUM  = 3'(NUM_REQ);
    localparam logic [1:0] LAST = 2'(NUM_REQ - 1);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] start;
    logic [3:0] req_pad;
    logic [2:0] cand;

    assign req_pad = 4'(req_i);
    assign start   = (ROUND_ROBIN != 0) ? ptr_q : 2'd0;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = 2'd0;
        cand    = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, start} + 3'(i);
            if (cand >= NUM) begin
                cand = cand - NUM;
            end
            if (req_pad[cand[1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if ((ROUND_ROBIN != 0) && advance_i) begin
            ptr_d = (idx_o == LAST) ? 2'd0 : idx_o + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sb_arbiter.sv
// ============================================================================
// Module      : sb_arbiter
// Description : One-at-a-time system-bus port sharing with alignment check
//               and response timeout watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_arbiter
    import sb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*3-1:0]      req_size,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_error,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [2:0]                mem_size,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_rsp_error,
    output logic                      busy,
    output logic [1:0]                grant_id
);

    localparam int             CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    sb_state_e         state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        grant_q, grant_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              arb_valid;
    logic [1:0]        arb_idx;
    logic              arb_advance;
    logic [3:0]        win_oh;
    logic [3:0]        grant_oh;

    // Pad per-requester fields to four slots so a 2-bit index is always legal.
    logic [3:0]        we_pad;
    logic [ADDR_W-1:0] addr_arr  [4];
    logic [DATA_W-1:0] wdata_arr [4];
    logic [2:0]        size_arr  [4];

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        if (g < NUM_REQ) begin : g_used
            assign we_pad[g]    = req_we[g];
            assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
            assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
            assign size_arr[g]  = req_size[g*3 +: 3];
        end else begin : g_pad
            assign we_pad[g]    = 1'b0;
            assign addr_arr[g]  = '0;
            assign wdata_arr[g] = '0;
            assign size_arr[g]  = 3'd0;
        end
    end

    sb_rr_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .advance_i (arb_advance),
        .valid_o   (arb_valid),
        .idx_o     (arb_idx)
    );

    assign arb_advance = (state_q == IDLE) && arb_valid;
    assign win_oh      = 4'b0001 << arb_idx;
    assign grant_oh    = 4'b0001 << grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 3'd0;
            grant_q <= 2'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            grant_q <= grant_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        grant_d = grant_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    we_d    = we_pad[arb_idx];
                    addr_d  = addr_arr[arb_idx];
                    wdata_d = wdata_arr[arb_idx];
                    size_d  = size_arr[arb_idx];
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (sb_misaligned(addr_arr[arb_idx][2:0], size_arr[arb_idx])) begin
                        err_d   = 1'b1;
                        state_d = RESPOND;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response arriving on the final count still takes priority.
                if (mem_rsp_valid) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    err_d   = mem_rsp_error;
                    state_d = RESPOND;
                end else if (cnt_q == CNT_MAX) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        mem_req_valid = 1'b0;
        case (state_q)
            IDLE:    req_ready     = arb_valid ? win_oh[NUM_REQ-1:0] : '0;
            ISSUE:   mem_req_valid = 1'b1;
            RESPOND: rsp_valid     = grant_oh[NUM_REQ-1:0];
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;
    assign rsp_rdata = rdata_q;
    assign rsp_error = err_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;

endmodule

`default_nettype wire

// File: tb/tb_sb_arbiter.sv
// ============================================================================
// Module      : tb_sb_arbiter
// Description : Scoreboard bench for sb_arbiter (round-robin and fixed-priority
//               instances, each with its own memory model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sb_arbiter;

    typedef struct packed {
        logic [1:0]  vld;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t a_exp[$];
    exp_t b_exp[$];
    exp_t ea, eb;

    // Instance A: round-robin; instance B: fixed priority.
    logic [1:0]   a_req_valid = '0, a_req_we = '0, a_req_ready, a_rsp_valid;
    logic [127:0] a_req_addr = '0, a_req_wdata = '0;
    logic [5:0]   a_req_size = '0;
    logic [63:0]  a_rsp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic         a_rsp_error, a_mem_req_valid, a_mem_we, a_mem_rsp_valid, a_busy;
    logic [2:0]   a_mem_size;
    logic [1:0]   a_grant_id;
    logic         a_mem_req_ready = 1'b1, a_mem_rsp_error = 1'b0;
    logic         a_noresp = 1'b0, a_inject = 1'b0, a_mem_seen = 1'b0;

    logic [1:0]   b_req_valid = '0, b_req_we = '0, b_req_ready, b_rsp_valid;
    logic [127:0] b_req_addr = '0, b_req_wdata = '0;
    logic [5:0]   b_req_size = '0;
    logic [63:0]  b_rsp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic         b_rsp_error, b_mem_req_valid, b_mem_we, b_mem_rsp_valid, b_busy;
    logic [2:0]   b_mem_size;
    logic [1:0]   b_grant_id;
    logic         b_mem_req_ready = 1'b1, b_mem_rsp_error = 1'b0;

    sb_arbiter #(.NUM_REQ(2), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(16), .ADDR_W(64), .DATA_W(64)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_size(a_req_size),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_error(a_rsp_error),
        .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_size(a_mem_size),
        .mem_rsp_valid(a_mem_rsp_valid), .mem_rdata(a_mem_rdata), .mem_rsp_error(a_mem_rsp_error),
        .busy(a_busy), .grant_id(a_grant_id)
    );

    sb_arbiter #(.NUM_REQ(2), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(16), .ADDR_W(64), .DATA_W(64)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_size(b_req_size),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_size(b_mem_size),
        .mem_rsp_valid(b_mem_rsp_valid), .mem_rdata(b_mem_rdata), .mem_rsp_error(b_mem_rsp_error),
        .busy(b_busy), .grant_id(b_grant_id)
    );

    function automatic logic [63:0] mem_data(input logic [63:0] addr);
        return (addr == 64'd0) ? 64'h00000000_DEADBEEF : {~addr[31:0], addr[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Zero-wait memories: response one cycle after accept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mem_rsp_valid <= 1'b0;
            a_mem_rdata     <= '0;
            b_mem_rsp_valid <= 1'b0;
            b_mem_rdata     <= '0;
        end else begin
            a_mem_rsp_valid <= (a_mem_req_valid && !a_noresp) || a_inject;
            a_mem_rdata     <= mem_data(a_mem_addr);
            b_mem_rsp_valid <= b_mem_req_valid;
            b_mem_rdata     <= mem_data(b_mem_addr);
        end
    end

    always @(negedge clk) begin
        if (a_mem_req_valid) a_mem_seen = 1'b1;
        if (rst_n && a_rsp_valid != 2'b00) begin
            if (a_exp.size() == 0) begin
                check("a_rsp_unexpected", {62'd0, a_rsp_valid}, 64'd0);
            end else begin
                ea = a_exp.pop_front();
                check("a_rsp_valid", {62'd0, a_rsp_valid}, {62'd0, ea.vld});
                check("a_rsp_rdata", a_rsp_rdata, ea.rdata);
                check("a_rsp_error", {63'd0, a_rsp_error}, {63'd0, ea.err});
            end
        end
        if (rst_n && b_rsp_valid != 2'b00) begin
            if (b_exp.size() == 0) begin
                check("b_rsp_unexpected", {62'd0, b_rsp_valid}, 64'd0);
            end else begin
                eb = b_exp.pop_front();
                check("b_rsp_valid", {62'd0, b_rsp_valid}, {62'd0, eb.vld});
                check("b_rsp_rdata", b_rsp_rdata, eb.rdata);
                check("b_rsp_error", {63'd0, b_rsp_error}, {63'd0, eb.err});
            end
        end
    end

    // Called just after a negedge; returns at the negedge after the grant.
    task automatic accept_a(input int r, input logic we, input logic [63:0] addr,
                            input logic [2:0] size, input logic [63:0] wdata);
        int  n = 0;
        logic seen = 1'b0;
        a_req_we[r]            = we;
        a_req_addr[r*64 +: 64] = addr;
        a_req_wdata[r*64 +: 64] = wdata;
        a_req_size[r*3 +: 3]   = size;
        a_req_valid[r]         = 1'b1;
        while (!seen && n < 50) begin
            #1;
            if (a_req_ready[r]) seen = 1'b1;
            @(negedge clk);
            n++;
        end
        check("a_accept", {63'd0, seen}, 64'd1);
        a_req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (a_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("a_idle", {63'd0, a_busy}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   g, cyc, last;
        logic seen;

        repeat (3) @(negedge clk);
        check("rst_busy",      {63'd0, a_busy}, 64'd0);
        check("rst_rsp_valid", {62'd0, a_rsp_valid}, 64'd0);
        check("rst_mem_valid", {63'd0, a_mem_req_valid}, 64'd0);
        check("rst_grant_id",  {62'd0, a_grant_id}, 64'd0);
        check("rst_rdata",     a_rsp_rdata, 64'd0);
        check("rst_b_busy",    {63'd0, b_busy}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin: both requesters continuously requesting.
        a_req_addr  = {64'h20, 64'h10};
        a_req_size  = {3'd3, 3'd3};
        for (int i = 0; i < 4; i++) begin
            a_exp.push_back('{vld: (i % 2 == 0) ? 2'b01 : 2'b10,
                              rdata: mem_data((i % 2 == 0) ? 64'h10 : 64'h20), err: 1'b0});
        end
        a_req_valid = 2'b11;
        g = 0; cyc = 0; last = 0;
        while (g < 4 && cyc < 100) begin
            #1;
            if (a_req_ready != 2'b00) begin
                check("rr_grant", {62'd0, a_req_ready}, (g % 2 == 0) ? 64'd1 : 64'd2);
                if (g > 0) check("rr_spacing", 64'(cyc - last), 64'd4);
                last = cyc;
                g++;
            end
            @(negedge clk);
            cyc++;
        end
        check("rr_grant_count", 64'(g), 64'd4);
        a_req_valid = 2'b00;
        wait_idle_a();

        // Fixed priority: requester 1 starved while requester 0 holds valid.
        b_req_addr = {64'h30, 64'h18};
        b_req_size = {3'd3, 3'd3};
        for (int i = 0; i < 4; i++) b_exp.push_back('{vld: 2'b01, rdata: mem_data(64'h18), err: 1'b0});
        b_req_valid = 2'b11;
        g = 0; cyc = 0;
        while (g < 4 && cyc < 100) begin
            #1;
            if (b_req_ready != 2'b00) begin
                check("fp_grant", {62'd0, b_req_ready}, 64'd1);
                g++;
            end
            @(negedge clk);
            cyc++;
        end
        check("fp_grant_count", 64'(g), 64'd4);
        b_req_valid = 2'b00;
        repeat (6) @(negedge clk);
        check("fp_idle", {63'd0, b_busy}, 64'd0);

        // Single read with zero-wait memory latency.
        a_exp.push_back('{vld: 2'b01, rdata: 64'h00000000_DEADBEEF, err: 1'b0});
        accept_a(0, 1'b0, 64'h0, 3'd3, 64'h0);
        check("rd_issue_valid", {63'd0, a_mem_req_valid}, 64'd1);
        check("rd_issue_addr",  a_mem_addr, 64'd0);
        check("rd_issue_size",  {61'd0, a_mem_size}, 64'd3);
        @(negedge clk);
        check("rd_wait_rsp",  {62'd0, a_rsp_valid}, 64'd0);
        check("rd_wait_busy", {63'd0, a_busy}, 64'd1);
        @(negedge clk);
        check("rd_cycle3_rsp", {62'd0, a_rsp_valid}, 64'd1);
        @(negedge clk);
        check("rd_done_busy", {63'd0, a_busy}, 64'd0);

        // Misaligned write from requester 1.
        a_mem_seen = 1'b0;
        a_exp.push_back('{vld: 2'b10, rdata: 64'd0, err: 1'b1});
        accept_a(1, 1'b1, 64'h6, 3'd2, 64'h1234);
        check("mis_rsp_now", {62'd0, a_rsp_valid}, 64'd2);
        wait_idle_a();
        repeat (2) @(negedge clk);
        check("mis_no_mem", {63'd0, a_mem_seen}, 64'd0);

        // Aligned halfword write: response data forced to zero.
        a_exp.push_back('{vld: 2'b10, rdata: 64'd0, err: 1'b0});
        accept_a(1, 1'b1, 64'h6, 3'd1, 64'hBEEF);
        wait_idle_a();

        // Timeout with a silent memory.
        a_noresp = 1'b1;
        a_exp.push_back('{vld: 2'b01, rdata: 64'd0, err: 1'b1});
        accept_a(0, 1'b0, 64'h40, 3'd3, 64'h0);
        cyc = 1;
        while (a_rsp_valid == 2'b00 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("to_latency", 64'(cyc), 64'd18);
        wait_idle_a();
        a_noresp = 1'b0;
        a_inject = 1'b1;
        @(negedge clk);
        a_inject = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen = seen | (a_rsp_valid != 2'b00) | a_busy;
        end
        check("late_rsp_ignored", {63'd0, seen}, 64'd0);
        a_exp.push_back('{vld: 2'b10, rdata: mem_data(64'h48), err: 1'b0});
        accept_a(1, 1'b0, 64'h48, 3'd3, 64'h0);
        wait_idle_a();

        // Reset during WAIT_RSP, after a grant to requester 0.
        a_noresp = 1'b1;
        accept_a(0, 1'b0, 64'h80, 3'd3, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",      {63'd0, a_busy}, 64'd0);
        check("mid_rst_rsp_valid", {62'd0, a_rsp_valid}, 64'd0);
        check("mid_rst_mem_valid", {63'd0, a_mem_req_valid}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a_noresp = 1'b0;
        a_req_addr = {64'hA0, 64'h90};
        a_req_size = {3'd3, 3'd3};
        a_req_we   = 2'b00;
        a_exp.push_back('{vld: 2'b01, rdata: mem_data(64'h90), err: 1'b0});
        a_req_valid = 2'b11;
        #1;
        check("post_rst_grant", {62'd0, a_req_ready}, 64'd1);
        @(negedge clk);
        a_req_valid = 2'b00;
        wait_idle_a();

        repeat (3) @(negedge clk);
        check("a_queue_empty", 64'(a_exp.size()), 64'd0);
        check("b_queue_empty", 64'(b_exp.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sb_arbiter.md
Name: sb_arbiter

Overview:
- Shares one system-bus memory port between NUM_REQ requesters, e.g. the debug module SBA port (index 0) and a hart load/store port (index 1).
- Sequences exactly one transaction at a time: arbitrate, issue, await response, return response.
- Adds an alignment check and a response timeout watchdog.
- Sits between riscv_debug_module / hart model and the system bus memory inside system_top.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ROUND_ROBIN, 1, 1 = round-robin arbitration; 0 = fixed priority with lowest index winning.
- TIMEOUT_CYCLES, 256, maximum cycles in WAIT_RSP before an error response is forced; must be at least 2.
- ADDR_W, 64, address width.
- DATA_W, 64, data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accepted (one-cycle pulse)
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_size  in  NUM_REQ*3  log2 of access bytes (0..3)
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the granted requester
- rsp_rdata  out  DATA_W  read data, valid while any rsp_valid is high
- rsp_error  out  1  error flag, qualified by rsp_valid
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accept
- mem_we  out  1  downstream write enable
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_size  out  3  downstream size
- mem_rsp_valid  in  1  downstream response pulse
- mem_rdata  in  DATA_W  downstream read data
- mem_rsp_error  in  1  downstream error
- busy  out  1  high in any state other than IDLE
- grant_id  out  2  index of the current or last granted requester

Behaviour:
- Reset values:
  - all outputs 0, state IDLE
  - round-robin pointer 0
  - timeout counter 0
  - captured request registers 0
- IDLE:
  - If any req_valid is high, select a winner.
  - ROUND_ROBIN=1: search starts at pointer and wraps modulo NUM_REQ. Pointer then becomes winner+1, wrapping to 0 past NUM_REQ-1.
  - ROUND_ROBIN=0: lowest index wins.
  - Pulse req_ready[winner] in the same cycle. Capture we/addr/wdata/size and set grant_id.
  - req_ready is combinational from state IDLE and req_valid.
- Alignment check on capture:
  - Misaligned when addr & ((1<<size)-1) is nonzero. Size greater than 3 is also an error.
  - Misaligned requests go to RESPOND with error=1 and no downstream request.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_req_valid=1 with the captured fields.
  - When mem_req_ready is high, go to WAIT_RSP and clear the timeout counter.
  - mem_* fields stay stable while mem_req_valid is high.
- WAIT_RSP:
  - On mem_rsp_valid, capture mem_rdata and mem_rsp_error, then go to RESPOND.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES-1 with no response, go to RESPOND with error=1 and rdata=0.
  - A response and the timeout in the same cycle: the response wins.
  - After a timeout, a late mem_rsp_valid arriving in RESPOND or IDLE is ignored.
- RESPOND:
  - rsp_valid[grant_id]=1 for exactly one cycle with rsp_rdata and rsp_error, then go to IDLE.
  - Write responses return rdata=0.
- Latency with a zero-wait memory (mem_req_ready=1, response one cycle after accept):
  - accept in cycle 0, issue in cycle 1, wait in cycle 2, rsp_valid in cycle 3
  - back-to-back grants every 4 cycles
- Requesters must hold req_* stable until req_ready. Deasserting req_valid before grant is allowed and causes no transaction.
- Reset mid-operation clears all state immediately. No response is owed after reset.

Decomposition:
- Package sb_arb_pkg holds:
  - state enum: IDLE, ISSUE, WAIT_RSP, RESPOND
  - size constants: SB_SIZE_B=0, SB_SIZE_H=1, SB_SIZE_W=2, SB_SIZE_D=3
  - the misalignment function
- One sub-module, sb_rr_arbiter: combinational NUM_REQ-way pick plus the pointer register, parameterized by ROUND_ROBIN.

Test Plan:
- Single read, requester 0, addr 0x0, size 3, memory returns 0x00000000_DEADBEEF one cycle after accept -> rsp_valid[0] in cycle 3 with rdata 0xDEADBEEF, error 0.
- Requesters 0 and 1 both request continuously, ROUND_ROBIN=1 -> grant sequence 0,1,0,1. Each rsp_valid goes only to its own requester.
- Same stimulus with ROUND_ROBIN=0 -> requester 0 is always granted and requester 1 is starved while req_valid[0] stays high.
- Requester 1 writes size 2 at addr 0x6 -> rsp_valid[1] with error=1 and mem_req_valid never asserted.
- Memory never responds, TIMEOUT_CYCLES=16 -> rsp_valid with error=1 exactly 16 cycles after entering WAIT_RSP. A mem_rsp_valid injected later is ignored and the next request completes normally.
- rst_n asserted during WAIT_RSP -> busy=0, all rsp_valid=0 and mem_req_valid=0 immediately; after release the first grant goes to requester 0.
